// File: rtl/filter_stream_driver_if.sv
// Valid/ready sample stream between the driver and its neighbours.
// master drives data/valid, slave drives ready.
interface filter_stream_driver_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/filter_stream_driver.sv
// Stream initiator for the FIR delay/all-pass filter core.
// Build option: FILTER_DRIVER_TIMEOUT_EN adds the WAIT watchdog.
module filter_stream_driver #(
  parameter int BITWIDTH_DATA  = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     EN,
  filter_stream_driver_if.slave    s,
  filter_stream_driver_if.master   m,
  output logic                     FLT_START,
  output logic [BITWIDTH_DATA-1:0] FLT_DATA_OUT,
  input  logic [BITWIDTH_DATA-1:0] FLT_DATA_IN,
  input  logic                     FLT_VALID,
  output logic                     BUSY,
  output logic                     ERR_TIMEOUT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = BITWIDTH_DATA;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_e;

  state_e state_q, state_d;
  logic   seen_q, seen_d;
  logic   pop, done;

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] flt_q;
  logic [W-1:0] m_data_q;
  logic         m_valid_q;
  logic         empty, full, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign s.ready = nRST && EN && !full;
  assign push    = s.valid && s.ready;

`ifdef FILTER_DRIVER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          tmo;
  logic          err_q;
`endif

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    pop     = 1'b0;
    done    = 1'b0;
`ifdef FILTER_DRIVER_TIMEOUT_EN
    tmo     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty && FLT_VALID && !m_valid_q)
          state_d = START;
      end
      START: begin
        seen_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!FLT_VALID)
          seen_d = 1'b1;
        // the filter must drop valid before its output counts
        if (seen_q && FLT_VALID) begin
          done    = 1'b1;
          pop     = 1'b1;
          state_d = IDLE;
        end
`ifdef FILTER_DRIVER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          pop     = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (!EN) begin
      state_d = IDLE;
      seen_d  = 1'b0;
      pop     = 1'b0;
      done    = 1'b0;
`ifdef FILTER_DRIVER_TIMEOUT_EN
      tmo     = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      flt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (!EN) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_q[AW-1:0]] <= s.data;
          wr_q <= wr_q + 1'b1;
        end
        if (pop)
          rd_q <= rd_q + 1'b1;
      end
      flt_q <= mem_q[rd_q[AW-1:0]];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else if (!EN) begin
      m_valid_q <= 1'b0;
    end else if (done) begin
      m_data_q  <= FLT_DATA_IN;
      m_valid_q <= 1'b1;
    end else if (m_valid_q && m.ready) begin
      m_valid_q <= 1'b0;
    end
  end

`ifdef FILTER_DRIVER_TIMEOUT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == START)
        cnt_q <= '0;
      else if (state_q == WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (!EN)
        err_q <= 1'b0;
      else if (tmo)
        err_q <= 1'b1;
    end
  end

  assign ERR_TIMEOUT = err_q;
`else
  assign ERR_TIMEOUT = 1'b0;
`endif

  assign FLT_START    = (state_q == START) && EN;
  assign FLT_DATA_OUT = flt_q;
  assign m.data       = m_data_q;
  assign m.valid      = m_valid_q;
  assign BUSY         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_filter_stream_driver.sv
// Scoreboard bench for filter_stream_driver with a 3-tap delay-line
// filter model; timeout checks are built with FILTER_DRIVER_TIMEOUT_EN.
module tb_filter_stream_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        flt_start;
  logic [15:0] flt_dout;
  logic [15:0] flt_din;
  logic        flt_valid;
  logic        busy;
  logic        err;
  logic        stuck = 1'b0;

  filter_stream_driver_if #(.W(16)) s_if ();
  filter_stream_driver_if #(.W(16)) m_if ();

  filter_stream_driver #(
    .BITWIDTH_DATA (16),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .EN          (en),
    .s           (s_if.slave),
    .m           (m_if.master),
    .FLT_START   (flt_start),
    .FLT_DATA_OUT(flt_dout),
    .FLT_DATA_IN (flt_din),
    .FLT_VALID   (flt_valid),
    .BUSY        (busy),
    .ERR_TIMEOUT (err)
  );

  always #5 clk = ~clk;

  // LENGTH=3 delay line; valid drops for one cycle per update
  logic [15:0] taps [3];
  logic        fv;
  logic [15:0] fout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps[0] <= '0;
      taps[1] <= '0;
      taps[2] <= '0;
      fv      <= 1'b1;
      fout    <= '0;
    end else if (flt_start && !stuck) begin
      taps[0] <= flt_dout;
      taps[1] <= taps[0];
      taps[2] <= taps[1];
      fv      <= 1'b0;
    end else if (!fv) begin
      fv   <= 1'b1;
      fout <= taps[2];
    end
  end

  assign flt_valid = fv;
  assign flt_din   = fout;

  int n_cmp = 0;
  int n_err = 0;
  int starts = 0;
  logic [15:0] sb [$];

  function automatic void chk(input string nm,
                              input logic [15:0] act,
                              input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  logic        hold_q = 1'b0;
  logic [15:0] held_q = '0;
  logic        prev_st = 1'b0;
  logic [15:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q  = 1'b0;
      prev_st = 1'b0;
    end else begin
      if (hold_q && m_if.valid)
        chk("m_data_stable", m_if.data, held_q);
      if (m_if.valid && m_if.ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %h expected none",
                   m_if.data);
        end else begin
          e = sb.pop_front();
          chk("m_data", m_if.data, e);
        end
      end
      hold_q = m_if.valid && !m_if.ready;
      held_q = m_if.data;
      if (flt_start) begin
        starts++;
        chk("start_rules", {14'd0, prev_st, m_if.valid}, 16'd0);
      end
      prev_st = flt_start;
    end
  end

  task automatic push(input logic [15:0] d,
                      input logic [15:0] x,
                      input bit track);
    int t;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = d;
    t = 0;
    while (!s_if.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_if.ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_wait: ready=0 required 1");
      s_if.valid = 1'b0;
      return;
    end
    if (track)
      sb.push_back(x);
    @(posedge clk);
    #1 s_if.valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy || m_if.valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", {15'd0, busy || m_if.valid},
        16'(sb.size() != 0));
    if (sb.size() != 0)
      sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int s0;
  int seen;

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b1;
    #2;
    chk("rst_s_ready", {15'd0, s_if.ready}, 16'd0);
    chk("rst_outs", {12'd0, flt_start, m_if.valid, busy, err},
        16'd0);
    chk("rst_flt_data", flt_dout, 16'd0);
    chk("rst_m_data", m_if.data, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // delay line 1..5 -> 0,0,1,2,3
    s0 = starts;
    push(16'd1, 16'd0, 1);
    push(16'd2, 16'd0, 1);
    push(16'd3, 16'd1, 1);
    push(16'd4, 16'd2, 1);
    push(16'd5, 16'd3, 1);
    drain();
    chk("start_count5", 16'(starts - s0), 16'd5);

    // single sample latency
    do_reset();
    push(16'h00AB, 16'h0000, 1);
    @(posedge clk); #1;
    chk("e1_start", {15'd0, flt_start}, 16'd1);
    chk("e1_flt_data", flt_dout, 16'h00AB);
    @(posedge clk); #1;
    chk("e2_start", {15'd0, flt_start}, 16'd0);
    @(posedge clk); #1;
    chk("e3_mvalid", {15'd0, m_if.valid}, 16'd0);
    @(posedge clk); #1;
    chk("e4_mvalid", {15'd0, m_if.valid}, 16'd1);
    chk("e4_busy", {15'd0, busy}, 16'd0);
    drain();

    // output stall with a filling FIFO
    do_reset();
    m_if.ready = 1'b0;
    s0 = starts;
    push(16'h0011, 16'h0000, 1);
    push(16'h0022, 16'h0000, 1);
    push(16'h0033, 16'h0011, 1);
    push(16'h0044, 16'h0022, 1);
    push(16'h0055, 16'h0033, 1);
    repeat (8) @(negedge clk);
    chk("full_s_ready", {15'd0, s_if.ready}, 16'd0);
    chk("stall_mvalid", {15'd0, m_if.valid}, 16'd1);
    chk("stall_starts", 16'(starts - s0), 16'd1);
    m_if.ready = 1'b1;
    push(16'h0066, 16'h0044, 1);
    drain();
    chk("stall_total", 16'(starts - s0), 16'd6);

    // EN=0 flush with full FIFO and held output
    do_reset();
    m_if.ready = 1'b0;
    push(16'h0101, 16'h0, 0);
    push(16'h0202, 16'h0, 0);
    push(16'h0303, 16'h0, 0);
    push(16'h0404, 16'h0, 0);
    push(16'h0505, 16'h0, 0);
    repeat (3) @(negedge clk);
    chk("pre_flush", {14'd0, s_if.ready, m_if.valid}, 16'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("flush_state", {13'd0, m_if.valid, busy, s_if.ready},
        16'd0);
    @(negedge clk);
    en = 1'b1;
    m_if.ready = 1'b1;

    // async reset in WAIT with 3 queued
    do_reset();
    push(16'h0A01, 16'h0, 0);
    push(16'h0A02, 16'h0, 0);
    push(16'h0A03, 16'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {11'd0, s_if.ready, flt_start, m_if.valid,
        busy, err}, 16'd0);
    chk("arst_flt_data", flt_dout, 16'd0);
    chk("arst_m_data", m_if.data, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_if.valid || busy)
        seen++;
    end
    chk("post_rst_quiet", 16'(seen), 16'd0);

`ifdef FILTER_DRIVER_TIMEOUT_EN
    do_reset();
    stuck = 1'b1;
    push(16'h0077, 16'h0, 0);
    repeat (9) @(posedge clk);
    #1 chk("tmo_early", {15'd0, err}, 16'd0);
    @(posedge clk); #1;
    chk("tmo_set", {13'd0, err, busy, m_if.valid}, 16'd4);
    stuck = 1'b0;
    push(16'h0088, 16'h0000, 1);
    drain();
    chk("tmo_sticky", {15'd0, err}, 16'd1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("tmo_clear", {15'd0, err}, 16'd0);
    @(negedge clk);
    en = 1'b1;
`else
    push(16'h0099, 16'h0000, 1);
    drain();
    chk("no_tmo_err", {15'd0, err}, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/filter_stream_driver.md
# filter_stream_driver

Stream-side initiator for the FIR delay/all-pass filter core. It accepts samples over a valid/ready stream and buffers them in a small FIFO. It launches one filter update per sample via a single-cycle start strobe, waits for the filter's valid/idle indication, and forwards the filter output on a valid/ready output stream. It sits between the ADC/sample source and the filter core, and between the filter core and downstream processing.

## Interface
- BITWIDTH_DATA, 16: sample width (input and output)
- FIFO_DEPTH, 4: input FIFO entries; must be a power of two, at least 2
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before abort (timeout build only)

- CLK  in  1  system clock; all logic on posedge
- nRST  in  1  asynchronous active-low reset
- EN  in  1  synchronous enable; low flushes the block
- S_DATA  in  BITWIDTH_DATA  input sample
- S_VALID  in  1  input sample valid
- S_READY  out  1  FIFO not full
- FLT_START  out  1  single-cycle start strobe to the filter
- FLT_DATA_OUT  out  BITWIDTH_DATA  sample presented to the filter input
- FLT_DATA_IN  in  BITWIDTH_DATA  filter output
- FLT_VALID  in  1  filter idle/valid indication
- M_DATA  out  BITWIDTH_DATA  output sample
- M_VALID  out  1  output sample valid
- M_READY  in  1  downstream accepts
- BUSY  out  1  FSM not in IDLE, or FIFO not empty
- ERR_TIMEOUT  out  1  sticky timeout flag

## Operation
- Reset values (async, nRST=0):
  - FSM=IDLE; FIFO empty.
  - S_READY=0 while in reset; S_READY=EN && !full afterwards.
  - FLT_START=0, FLT_DATA_OUT=0, M_DATA=0, M_VALID=0, BUSY=0, ERR_TIMEOUT=0.
- Input FIFO:
  - Push when S_VALID && S_READY.
  - Pop only on leaving WAIT.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - A simultaneous push and pop is legal when the FIFO is full; S_READY still reflects the registered full state.
- FLT_DATA_OUT always equals the FIFO head, registered, and is held stable from START until the pop.
- FSM states:
  - IDLE -> START when the FIFO is non-empty, FLT_VALID=1 and M_VALID=0.
  - START: FLT_START=1 for exactly this cycle; go to WAIT.
  - WAIT: a seen_low flag is set when FLT_VALID=0.
    - When seen_low && FLT_VALID: M_DATA<=FLT_DATA_IN, M_VALID<=1, pop FIFO, go to IDLE.
    - Timeout (build option): if the WAIT cycle count reaches TIMEOUT_CYCLES, set ERR_TIMEOUT, pop (drop the sample), leave M_VALID unchanged, go to IDLE.
- Output register: M_VALID is held until M_VALID && M_READY, then cleared. M_DATA is stable while M_VALID=1.
- EN=0 (synchronous):
  - FSM->IDLE, FIFO cleared, M_VALID=0, ERR_TIMEOUT cleared.
  - FLT_START is forced 0; no new pushes.
- Arithmetic: none on data; samples pass through bit-exact.

## Timing
- Latency: S handshake at edge e0 -> M_VALID=1 after edge e4, with FLT_START high between e1 and e2 and the filter responding in one cycle.
- Throughput: one sample per 4 cycles at best, plus one cycle per M_VALID stall.
- FLT_START never occurs in two consecutive cycles.
- FLT_START is never issued while M_VALID=1.
- nRST low mid-WAIT aborts immediately; no partial output is produced.
- If FLT_VALID stays high after START (no drop is seen), WAIT keeps waiting; this counts toward the timeout when enabled.

## Configuration
- FILTER_DRIVER_TIMEOUT_EN defined:
  - The WAIT cycle counter ($clog2(TIMEOUT_CYCLES+1) bits) and abort path are built.
  - ERR_TIMEOUT is live.
- FILTER_DRIVER_TIMEOUT_EN undefined:
  - No counter is built; WAIT waits indefinitely.
  - ERR_TIMEOUT is tied to 0.

## Test plan
- Filter model is a LENGTH=3 delay line. Push inputs 1,2,3,4,5 with M_READY=1 -> M_DATA sequence 0,0,1,2,3. Exactly 5 FLT_START pulses, each one cycle wide.
- Single sample 0x00AB, filter model responding in one cycle -> FLT_START high in cycle e1 and M_VALID=1 after edge e4. BUSY=0 again the cycle after the pop.
- Hold M_READY=0 with 6 pushes, FIFO_DEPTH=4 -> one output is held with M_DATA stable. S_READY=0 after the FIFO fills. No further FLT_START until M_READY=1.
- Timeout build, filter model whose FLT_VALID never drops, TIMEOUT_CYCLES=8 -> ERR_TIMEOUT=1 after 8 WAIT cycles and the sample is dropped. ERR_TIMEOUT stays 1 through later good samples; EN=0 for one cycle clears it.
- Assert nRST=0 during WAIT with 3 samples queued -> all outputs at reset values asynchronously. After release, no M_VALID appears without new input.
- Set EN=0 with a full FIFO and M_VALID=1 -> next cycle M_VALID=0, FIFO empty, BUSY=0 and S_READY=0 while EN=0.
